// File: rtl/uart_rx_pkg.sv
// Shared UART receiver types and default frame geometry.
package uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } state_t;

endpackage

// File: rtl/flex_counter.sv
// Free-running period counter: counts 0..rollover_val-1 and flags the last count.
// rollover_flag is combinational from count_out; clear restarts the period next cycle.
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  assign rollover_flag = count_enable && (count_out == rollover_val - ONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= rollover_flag ? '0 : count_out + ONE;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: start-edge detect, mid-bit sampling, LSB-first capture, error flags.
// data_ready rises about 98 clocks after the start edge at CLKS_PER_BIT=10.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] BIT_PERIOD = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  state_t state, next_state;

  logic [1:0]           sync_q;
  logic [1:0]           flush_q;
  logic                 sin;
  logic                 sin_prev;
  logic                 fall;
  logic                 edge_pend;
  logic [TW-1:0]        timer;
  logic                 strobe;
  logic                 timer_clear;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 load;
  logic                 fe_set;
  logic                 fe_clr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end

  assign sin = sync_q[1];

  // History only trusts sin once the reset value has flushed out of the
  // synchronizer, so a line held low across reset never looks like an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      flush_q   <= 2'b00;
      sin_prev  <= 1'b0;
      edge_pend <= 1'b0;
    end else begin
      flush_q   <= {flush_q[0], 1'b1};
      sin_prev  <= flush_q[1] & sin;
      edge_pend <= (state == LOAD) & fall;
    end
  end

  assign fall = sin_prev & ~sin;

  flex_counter #(
    .NUM_BITS(TW)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clear),
    .count_enable (1'b1),
    .rollover_val (BIT_PERIOD),
    .count_out    (timer),
    .rollover_flag(strobe)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    timer_clear = 1'b0;
    load        = 1'b0;
    fe_set      = 1'b0;
    fe_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (fall || edge_pend) begin
          next_state = START;
          fe_clr     = 1'b1;
        end
      end
      START: begin
        if (timer == HALF_LAST) begin
          next_state = sin ? IDLE : DATA;
        end
      end
      DATA: begin
        if (strobe && (bit_cnt == LAST_BIT)) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          next_state = sin ? LOAD : IDLE;
          fe_set     = ~sin;
        end
      end
      LOAD: begin
        next_state = IDLE;
        load       = 1'b1;
      end
      default: next_state = IDLE;
    endcase
    timer_clear = (next_state != state) || (state == IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (state == START) begin
      bit_cnt <= '0;
    end else if ((state == DATA) && strobe) begin
      bit_cnt <= bit_cnt + BW'(1);
      shift_q <= {sin, shift_q[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      // A read in the load cycle retires the old byte, so the new one wins cleanly.
      if (load) begin
        rx_data    <= shift_q;
        data_ready <= 1'b1;
        if (data_read) begin
          overrun_error <= 1'b0;
        end else if (data_ready) begin
          overrun_error <= 1'b1;
        end
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (fe_clr) begin
        framing_error <= 1'b0;
      end else if (fe_set) begin
        framing_error <= 1'b1;
      end
    end
  end

endmodule
